// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arbiter
// Purpose  : Round-robin sharing of one iterative multiplier among NUM_REQ
//            requesters. Optional macro MULT_ARB_ZERO_BYPASS_EN short-cuts
//            zero-operand requests.
// Revision : 1.0  initial release
// ============================================================================
module mult_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH_IN   = 8,
  parameter int WIDTH_OUT  = 16,
  parameter int SETTLE_CYC = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*WIDTH_IN-1:0]  req_multiplicand,
  input  logic [NUM_REQ*WIDTH_IN-1:0]  req_multiplier,
  output logic [WIDTH_IN-1:0]          mul_multiplicand,
  output logic [WIDTH_IN-1:0]          mul_multiplier,
  input  logic [WIDTH_OUT-1:0]         mul_product,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [WIDTH_OUT-1:0]         rsp_product,
  output logic                         busy
);

  localparam int c_id_w  = $clog2(NUM_REQ);
  localparam int c_cnt_w = $clog2(2**WIDTH_IN + SETTLE_CYC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_id_w-1:0]    r_last_grant;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [WIDTH_IN-1:0]  r_mul_mcand;
  logic [WIDTH_IN-1:0]  r_mul_mplier;
  logic                 r_rsp_valid;
  logic [c_id_w-1:0]    r_rsp_id;
  logic [WIDTH_OUT-1:0] r_rsp_product;
  logic                 r_busy;
`ifdef MULT_ARB_ZERO_BYPASS_EN
  logic                 r_zero;
`endif

  logic                 w_found;
  logic [c_id_w-1:0]    w_idx;
  logic [c_id_w-1:0]    w_grant_idx;
  logic [WIDTH_IN-1:0]  w_sel_mcand;
  logic [WIDTH_IN-1:0]  w_sel_mplier;

  // Rotating search starting just above the previous winner.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_idx       = r_last_grant;
    req_ready   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (w_idx == c_id_w'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
      if (!w_found && req_valid[w_idx]) begin
        w_found     = 1'b1;
        w_grant_idx = w_idx;
      end
    end
    if (r_state != S_IDLE) begin
      w_found = 1'b0;
    end
    if (w_found) begin
      req_ready[w_grant_idx] = 1'b1;
    end
  end

  assign w_sel_mcand  = req_multiplicand[w_grant_idx*WIDTH_IN +: WIDTH_IN];
  assign w_sel_mplier = req_multiplier[w_grant_idx*WIDTH_IN +: WIDTH_IN];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= S_IDLE;
      r_last_grant  <= c_id_w'(NUM_REQ - 1);
      r_cnt         <= '0;
      r_mul_mcand   <= '0;
      r_mul_mplier  <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_product <= '0;
      r_busy        <= 1'b0;
`ifdef MULT_ARB_ZERO_BYPASS_EN
      r_zero        <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_last_grant <= w_grant_idx;
            r_rsp_id     <= w_grant_idx;
            r_busy       <= 1'b1;
            r_state      <= S_WAIT;
`ifdef MULT_ARB_ZERO_BYPASS_EN
            // A zero operand needs no multiplier run; one WAIT pass with cnt=0.
            r_zero <= (w_sel_mcand == '0) || (w_sel_mplier == '0);
            if ((w_sel_mcand == '0) || (w_sel_mplier == '0)) begin
              r_cnt <= '0;
            end else begin
              r_mul_mcand  <= w_sel_mcand;
              r_mul_mplier <= w_sel_mplier;
              r_cnt        <= c_cnt_w'(w_sel_mplier) + c_cnt_w'(SETTLE_CYC);
            end
`else
            r_mul_mcand  <= w_sel_mcand;
            r_mul_mplier <= w_sel_mplier;
            r_cnt        <= c_cnt_w'(w_sel_mplier) + c_cnt_w'(SETTLE_CYC);
`endif
          end
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_cnt_w'(1);
          end else begin
`ifdef MULT_ARB_ZERO_BYPASS_EN
            r_rsp_product <= r_zero ? '0 : mul_product;
`else
            r_rsp_product <= mul_product;
`endif
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mul_multiplicand = r_mul_mcand;
  assign mul_multiplier   = r_mul_mplier;
  assign rsp_valid        = r_rsp_valid;
  assign rsp_id           = r_rsp_id;
  assign rsp_product      = r_rsp_product;
  assign busy             = r_busy;

endmodule
`default_nettype wire

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin controller that shares one `repeated_add_multiplier` instance between `NUM_REQ` requesters. It accepts one operand pair at a time through a valid/ready handshake and drives the multiplier's operand inputs from registers. The multiplier has no done flag, so the block waits a data-dependent number of cycles for the iterative result to settle, then returns the captured product tagged with the requester ID. It sits between the readout-side compute clients and the single shared multiplier.

## Interface
- `NUM_REQ`, 4 — number of requesters, ≥2.
- `WIDTH_IN`, 8 — operand width; must match the multiplier instance.
- `WIDTH_OUT`, 16 — product width; must equal 2·`WIDTH_IN`.
- `SETTLE_CYC`, 2 — extra wait cycles beyond the multiplier operand value.
- `CLK` in 1 — clock; all state updates on the rising edge.
- `RST` in 1 — asynchronous, active-high reset.
- `req_valid` in `NUM_REQ` — one request-valid bit per requester.
- `req_ready` out `NUM_REQ` — one-hot grant; a transfer occurs on a cycle where valid & ready.
- `req_multiplicand` in `NUM_REQ*WIDTH_IN` — packed operands; requester i is at bits [i*WIDTH_IN +: WIDTH_IN].
- `req_multiplier` in `NUM_REQ*WIDTH_IN` — packed operands, same packing.
- `mul_multiplicand` out `WIDTH_IN` — drives the multiplier's `multiplicand` input; registered.
- `mul_multiplier` out `WIDTH_IN` — drives the multiplier's `multiplier` input; registered.
- `mul_product` in `WIDTH_OUT` — the multiplier's `product` output.
- `rsp_valid` out 1 — result available.
- `rsp_ready` in 1 — consumer accepts the result.
- `rsp_id` out `$clog2(NUM_REQ)` — index of the requester that owns the result.
- `rsp_product` out `WIDTH_OUT` — captured product.
- `busy` out 1 — high when the state is not IDLE.

## Operation
**States:** IDLE, WAIT, RESP.

**IDLE**
- `req_ready` is combinational.
- It selects the first `req_valid` bit, searching upward from `(last_grant+1) mod NUM_REQ` with wrap-around.
- All `req_ready` bits are 0 in WAIT and RESP.

**Accept (IDLE, some valid & ready, granted index g)**
- Latch the operands of g into the `mul_*` registers.
- Set `rsp_id` = g and `last_grant` = g.
- Load `cnt` = `req_multiplier[g]` + `SETTLE_CYC`, then enter WAIT.

**WAIT**
- If `cnt`≠0, decrement `cnt`.
- If `cnt`=0, capture `rsp_product` ← `mul_product` and go to RESP.

**RESP**
- `rsp_valid`=1. `rsp_product` and `rsp_id` are held stable until `rsp_ready`=1.
- On that edge, clear `rsp_valid` and return to IDLE.

**Widths and holding**
- `cnt` is `$clog2(2**WIDTH_IN + SETTLE_CYC)` bits wide, so there is no overflow at operand 255.
- `mul_*` keep their last operands after completion; they are only rewritten on accept.

**Boundaries**
- Requests that are not granted must hold `req_valid` and their operands; the arbiter does not buffer them.
- Only one operation is in flight. `req_valid` during WAIT or RESP is ignored until IDLE.
- `rsp_ready` held high before RESP has no effect.
- RST asserted mid-operation aborts any operation in progress. Every register returns to its reset value immediately and the in-flight result is dropped.
- Reset values: state IDLE, `req_ready`=0 (until IDLE evaluation), `mul_multiplicand`=0, `mul_multiplier`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_product`=0, `busy`=0, `cnt`=0, `last_grant`=`NUM_REQ-1` (requester 0 has first priority).

## Timing
- Accept at edge k → `rsp_valid` rises after edge k+`multiplier`+`SETTLE_CYC`+1.
- Example: multiplier 0 with `SETTLE_CYC`=2 gives a latency of 3 cycles.
- Minimum period between accepts is `multiplier`+`SETTLE_CYC`+3 cycles: the WAIT cycles, 1 RESP cycle with `rsp_ready`=1, then 1 IDLE cycle.
- `mul_*` change exactly one edge after acceptance. The `SETTLE_CYC` margin covers the multiplier's restart after an operand change.
- `req_ready` has a combinational path from `req_valid`. All other outputs are registered.

## Configuration
- `MULT_ARB_ZERO_BYPASS_EN` defined:
  - An accepted request with either operand = 0 skips WAIT.
  - RESP is entered on the edge after accept with `rsp_product`=0; latency is 1 cycle.
  - `mul_*` are not updated.
- Undefined: every request takes the full WAIT path, including zero operands.

## Test plan
- **Single request.** Reset, then req1 = (13, 7) → `req_ready[1]` in the same cycle. `mul_*` = 13/7 one edge later. `rsp_valid` 10 cycles after accept with `rsp_product`=91 and `rsp_id`=1.
- **Round-robin fairness.** All 4 `req_valid` held, operands (i+1, 3), `rsp_ready`=1 → grants in order 0,1,2,3,0. Products 3, 6, 9, 12.
- **Backpressure.** `rsp_ready`=0 for 5 cycles after `rsp_valid` → `rsp_product`/`rsp_id` stable, no new grant while req2 is valid. Releasing `rsp_ready` lets req2 be granted after one IDLE cycle.
- **Maximum operands.** (255, 255) → result 65025 after 258 cycles. `cnt` does not wrap.
- **Reset mid-operation.** Assert RST during WAIT of (200, 200) → all outputs zero at once. After release, req3 alone is granted first and returns the correct product.
- **Zero operand.** (0, 9) → with `MULT_ARB_ZERO_BYPASS_EN`, `rsp_valid` 1 cycle after accept with result 0. Without the macro, `rsp_valid` after 12 cycles with result 0.
